cgb_palette_ctrl: RTL and testbench

- CPU-side controller for the CGB background and sprite colour palette RAMs.
- Implements the BCPS/BCPD (FF68/FF69) and OCPS/OCPD (FF6A/FF6B) register pair semantics: index registers, auto-increment, a one-deep write-commit pipeline with read forwarding, and DMG-mode gating.
- Drives the address, write data and write strobes of the palette RAM inside the pixel colouring stage, and returns CPU read data.

---
 rtl/cgb_palette_ctrl.sv | 117 +++++++++++
 tb/tb_cgb_palette_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cgb_palette_ctrl.sv
// CPU-side BCPS/BCPD and OCPS/OCPD controller for the CGB palette RAMs.
// Mode-3 data lockout is compiled in with `define CGB_PALETTE_MODE3_LOCK_EN.
module cgb_palette_ctrl #(
  parameter logic [7:0] LOCK_RDATA = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       cgb,
  input  logic       ppu_enable,
  input  logic [1:0] ppu_mode,
  input  logic [1:0] reg_sel,
  input  logic       reg_write,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic [5:0] bg_palette_addr,
  output logic [5:0] sp_palette_addr,
  output logic [7:0] palette_wdata,
  output logic [1:0] palette_write,
  input  logic [7:0] bg_palette_rdata,
  input  logic [7:0] sp_palette_rdata
);

  typedef enum logic {TGT_BG = 1'b0, TGT_SP = 1'b1} target_e;

  typedef struct packed {
    logic       valid;
    target_e    tgt;
    logic [5:0] addr;
    logic [7:0] data;
  } pend_t;

`ifdef CGB_PALETTE_MODE3_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic [5:0] bg_idx, sp_idx;
  logic       bg_ai, sp_ai;
  pend_t      pend;
  logic [5:0] commit_addr;

  logic       locked;
  logic       idx_wr, data_wr, data_accept;
  target_e    sel_tgt;
  logic [5:0] sel_idx;
  logic       sel_ai;

  assign locked      = LOCK_EN & cgb & ppu_enable & (ppu_mode == 2'd3);
  assign sel_tgt     = target_e'(reg_sel[1]);
  assign sel_idx     = reg_sel[1] ? sp_idx : bg_idx;
  assign sel_ai      = reg_sel[1] ? sp_ai  : bg_ai;
  assign idx_wr      = cpu_en & reg_write & ~reg_sel[0];
  // DMG-mode data writes vanish completely: no commit and no increment.
  assign data_wr     = cpu_en & reg_write & reg_sel[0] & cgb;
  assign data_accept = data_wr & ~locked;

  // NOTE: every state element below uses <= so all of them see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bg_idx        <= '0;
      sp_idx        <= '0;
      bg_ai         <= 1'b0;
      sp_ai         <= 1'b0;
      pend          <= '0;
      commit_addr   <= '0;
      palette_write <= 2'b00;
      palette_wdata <= 8'h00;
    end else begin
      if (idx_wr) begin
        if (reg_sel[1]) {sp_ai, sp_idx} <= {reg_wdata[7], reg_wdata[5:0]};
        else            {bg_ai, bg_idx} <= {reg_wdata[7], reg_wdata[5:0]};
      end else if (data_wr && sel_ai) begin
        if (reg_sel[1]) sp_idx <= sp_idx + 6'd1;
        else            bg_idx <= bg_idx + 6'd1;
      end

      // The entry drains every cycle, so a write accepted now simply refills it.
      pend.valid <= data_accept;
      if (data_accept) begin
        pend.tgt  <= sel_tgt;
        pend.addr <= sel_idx;
        pend.data <= reg_wdata;
      end

      palette_write <= {pend.valid && (pend.tgt == TGT_SP),
                        pend.valid && (pend.tgt == TGT_BG)};
      if (pend.valid) begin
        palette_wdata <= pend.data;
        commit_addr   <= pend.addr;
      end
    end
  end

  // The strobe cycle owns the port so the RAM writes at the committed address.
  assign bg_palette_addr = palette_write[0]                        ? commit_addr :
                           (pend.valid && pend.tgt == TGT_BG)      ? pend.addr   : bg_idx;
  assign sp_palette_addr = palette_write[1]                        ? commit_addr :
                           (pend.valid && pend.tgt == TGT_SP)      ? pend.addr   : sp_idx;

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    reg_rdata = LOCK_RDATA;
    if (cgb) begin
      if (!reg_sel[0]) begin
        reg_rdata = {sel_ai, 1'b1, sel_idx};
      end else if (!locked) begin
        if (pend.valid && pend.tgt == sel_tgt && pend.addr == sel_idx)
          reg_rdata = pend.data;
        else
          reg_rdata = reg_sel[1] ? sp_palette_rdata : bg_palette_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cgb_palette_ctrl.sv
// Bench for cgb_palette_ctrl: directed steps then random traffic against a
// timeline model of index registers, palette contents and expected commits.
module tb_cgb_palette_ctrl;

`ifdef CGB_PALETTE_MODE3_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_en, cgb, ppu_enable, reg_write;
  logic [1:0] ppu_mode, reg_sel;
  logic [7:0] reg_wdata, reg_rdata;
  logic [5:0] bg_palette_addr, sp_palette_addr;
  logic [7:0] palette_wdata;
  logic [1:0] palette_write;
  logic [7:0] bg_palette_rdata, sp_palette_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // Palette RAMs as seen by the DUT.
  logic [7:0] ram [2][64];
  logic       force_zero = 1'b0;

  always #5 clk = ~clk;

  cgb_palette_ctrl dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .cgb(cgb),
    .ppu_enable(ppu_enable), .ppu_mode(ppu_mode), .reg_sel(reg_sel),
    .reg_write(reg_write), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .bg_palette_addr(bg_palette_addr), .sp_palette_addr(sp_palette_addr),
    .palette_wdata(palette_wdata), .palette_write(palette_write),
    .bg_palette_rdata(bg_palette_rdata), .sp_palette_rdata(sp_palette_rdata)
  );

  assign bg_palette_rdata = force_zero ? 8'h00 : ram[0][bg_palette_addr];
  assign sp_palette_rdata = force_zero ? 8'h00 : ram[1][sp_palette_addr];

  always @(posedge clk) begin
    if (palette_write[0]) ram[0][bg_palette_addr] <= palette_wdata;
    if (palette_write[1]) ram[1][sp_palette_addr] <= palette_wdata;
  end

  // Reference model: a write accepted at edge k strobes in the cycle after
  // edge k+1 and lands in the RAM at edge k+2.
  typedef struct {
    int         due;
    bit         tgt;
    logic [5:0] addr;
    logic [7:0] data;
  } cmt_t;

  cmt_t       q[$];
  cmt_t       strb;
  bit         strb_v = 1'b0;
  int         cyc_n = 0;
  logic [5:0] m_idx [2];
  bit         m_ai  [2];
  logic [7:0] m_mem [2][64];

  function automatic bit m_locked();
    return LOCK_EN && cgb && ppu_enable && (ppu_mode == 2'd3);
  endfunction

  function automatic logic [5:0] exp_port(input bit t);
    if (strb_v && strb.tgt == t) return strb.addr;
    foreach (q[i]) if (q[i].due == cyc_n + 1 && q[i].tgt == t) return q[i].addr;
    return m_idx[t];
  endfunction

  function automatic logic [7:0] exp_read(input logic [1:0] sel);
    bit t;
    t = sel[1];
    if (!cgb) return 8'hFF;
    if (!sel[0]) return {m_ai[t], 1'b1, m_idx[t]};
    if (m_locked()) return 8'hFF;
    foreach (q[i])
      if (q[i].due == cyc_n + 1 && q[i].tgt == t && q[i].addr == m_idx[t]) return q[i].data;
    if (force_zero) return 8'h00;
    return m_mem[t][exp_port(t)];
  endfunction

  task automatic model_reset();
    q.delete();
    strb_v = 1'b0;
    for (int t = 0; t < 2; t++) begin
      m_idx[t] = '0;
      m_ai[t]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit t;
    cyc_n++;
    if (strb_v) m_mem[strb.tgt][strb.addr] = strb.data;
    strb_v = 1'b0;
    if (q.size() > 0 && q[0].due == cyc_n) begin
      strb   = q.pop_front();
      strb_v = 1'b1;
    end
    if (cpu_en && reg_write) begin
      t = reg_sel[1];
      if (!reg_sel[0]) begin
        m_idx[t] = reg_wdata[5:0];
        m_ai[t]  = reg_wdata[7];
      end else if (cgb) begin
        if (!m_locked()) q.push_back('{cyc_n + 1, t, m_idx[t], reg_wdata});
        if (m_ai[t]) m_idx[t] = m_idx[t] + 6'd1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, check combinational outputs at negedge,
  // advance the model at posedge, check registered outputs at posedge+1.
  task automatic cyc(input logic [1:0] sel, input logic wr, input logic [7:0] wd);
    reg_sel = sel; reg_write = wr; reg_wdata = wd;
    @(negedge clk);
    check("rdata", reg_rdata, exp_read(sel));
    check("bg_addr", {2'b00, bg_palette_addr}, {2'b00, exp_port(1'b0)});
    check("sp_addr", {2'b00, sp_palette_addr}, {2'b00, exp_port(1'b1)});
    @(posedge clk);
    model_edge();
    #1;
    check("strobe", {6'd0, palette_write}, strb_v ? (8'd1 << strb.tgt) : 8'd0);
    if (strb_v) begin
      check("wdata", palette_wdata, strb.data);
      check("waddr", {2'b00, strb.tgt ? sp_palette_addr : bg_palette_addr}, {2'b00, strb.addr});
    end
  endtask

  task automatic peek(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    reg_sel = sel; reg_write = 1'b0;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 64; a++) begin
        ram[t][a]   = 8'h00;
        m_mem[t][a] = 8'h00;
      end
    model_reset();
    reset = 1'b0; cpu_en = 1'b1; cgb = 1'b1; ppu_enable = 1'b0; ppu_mode = 2'd0;
    reg_sel = 2'd0; reg_write = 1'b0; reg_wdata = 8'h00;

    // Reset state.
    #1;
    check("rst_strobe", {6'd0, palette_write}, 8'h00);
    check("rst_wdata", palette_wdata, 8'h00);
    peek("rst_bcps", 2'd0, 8'h40);
    peek("rst_ocps", 2'd2, 8'h40);
    @(posedge clk); #1;
    reset = 1'b1;

    // BG auto-increment writes, back to back.
    cyc(2'd0, 1'b1, 8'h80);
    cyc(2'd1, 1'b1, 8'h1F);
    cyc(2'd1, 1'b1, 8'h7C);
    check("t1_strobe0", {6'd0, palette_write}, 8'h01);
    check("t1_addr0", {2'b00, bg_palette_addr}, 8'h00);
    check("t1_data0", palette_wdata, 8'h1F);
    cyc(2'd0, 1'b0, 8'h00);
    check("t1_strobe1", {6'd0, palette_write}, 8'h01);
    check("t1_addr1", {2'b00, bg_palette_addr}, 8'h01);
    check("t1_data1", palette_wdata, 8'h7C);
    peek("t1_bcps", 2'd0, 8'hC2);

    // Sprite index wraps from 63 to 0.
    cyc(2'd2, 1'b1, 8'hBF);
    cyc(2'd3, 1'b1, 8'h55);
    cyc(2'd0, 1'b0, 8'h00);
    check("t2_strobe", {6'd0, palette_write}, 8'h02);
    check("t2_addr", {2'b00, sp_palette_addr}, 8'h3F);
    peek("t2_ocps", 2'd2, 8'hC0);

    // Mode 3 with the LCD on.
    ppu_enable = 1'b1; ppu_mode = 2'd3;
    cyc(2'd0, 1'b1, 8'h85);
    cyc(2'd1, 1'b1, 8'hAA);
    peek("t3_bcpd", 2'd1, LOCK_EN ? 8'hFF : 8'h00);
    cyc(2'd0, 1'b0, 8'h00);
    check("t3_strobe", {6'd0, palette_write}, LOCK_EN ? 8'h00 : 8'h01);
    peek("t3_bcps", 2'd0, 8'hC6);
    ppu_enable = 1'b0; ppu_mode = 2'd0;

    // DMG mode ignores data writes and hides the registers.
    cgb = 1'b0;
    cyc(2'd1, 1'b1, 8'h12);
    cyc(2'd0, 1'b0, 8'h00);
    check("t4_strobe", {6'd0, palette_write}, 8'h00);
    peek("t4_bcps", 2'd0, 8'hFF);
    peek("t4_bcpd", 2'd1, 8'hFF);
    cgb = 1'b1;
    peek("t4_idx_kept", 2'd0, 8'hC6);

    // Read forwarding from the pending entry.
    cyc(2'd0, 1'b1, 8'h04);
    force_zero = 1'b1;
    cyc(2'd1, 1'b1, 8'h3C);
    peek("t5_forward", 2'd1, 8'h3C);
    force_zero = 1'b0;
    cyc(2'd0, 1'b0, 8'h00);
    check("t5_strobe", {6'd0, palette_write}, 8'h01);
    check("t5_addr", {2'b00, bg_palette_addr}, 8'h04);

    // Reset mid-pipeline discards the pending write.
    cyc(2'd3, 1'b1, 8'h77);
    reg_write = 1'b0;
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
    cyc(2'd0, 1'b0, 8'h00);
    check("t6_no_strobe", {6'd0, palette_write}, 8'h00);
    cyc(2'd0, 1'b0, 8'h00);
    peek("t6_bcps", 2'd0, 8'h40);
    peek("t6_ocps", 2'd2, 8'h40);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cpu_en     = ($urandom_range(0, 7) != 0);
      cgb        = ($urandom_range(0, 9) != 0);
      ppu_enable = 1'($urandom_range(0, 1));
      ppu_mode   = 2'($urandom_range(0, 3));
      cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
